// File: rtl/led7_pkg.sv
// Shared constants, scan state type and a width helper for the 7-segment scan controller.
package led7_pkg;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_DASH  = 4'hA;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/led7_scan_ctrl_blink.sv
// Blink phase generator: toggles the phase every BLINK_FRAMES frame wraps.
module led7_blink_gen
    import led7_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 62
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wrap_i,
    // Next-state phase, so the parent can register outputs on the wrap edge itself.
    output logic blink_phase_next_o
);

    localparam int unsigned FrW = clog2(BLINK_FRAMES);

    logic [FrW-1:0] fr_q, fr_d;
    logic           phase_q, phase_d;

    // Count wraps; clear on the last frame of a phase and flip the phase.
    always_comb begin
        fr_d    = fr_q;
        phase_d = phase_q;
        if (wrap_i) begin
            if (fr_q == FrW'(BLINK_FRAMES - 1)) begin
                fr_d    = '0;
                phase_d = ~phase_q;
            end else begin
                fr_d = fr_q + FrW'(1);
            end
        end
    end

    // Frame counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            fr_q    <= fr_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase_next_o = phase_d;

endmodule

// File: rtl/led7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank with anti-ghost gaps,
// tear-free snapshot loading and per-digit blinking.
module led7_scan_ctrl
    import led7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DWELL_CYC    = 50000,
    parameter int unsigned GAP_CYC      = 500,
    parameter int unsigned BLINK_FRAMES = 62
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic [3:0]              code_o,
    output logic [NUM_DIGITS-1:0]   an_n_o,
    output logic [2:0]              digit_idx_o,
    output logic                    frame_done_o
);

    localparam int unsigned CntMax = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
    localparam int unsigned CntW   = clog2(CntMax);
    localparam int unsigned DataW  = 4 * NUM_DIGITS;

    scan_state_e            st_q, st_d;
    logic [2:0]             idx_q, idx_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [DataW-1:0]       snap_q, snap_d;
    logic [DataW-1:0]       pend_q, pend_d;
    logic                   pflag_q, pflag_d;
    logic                   wrap;
    logic                   blink_phase_d;

    logic [3:0]             cur_code;
    logic                   cur_mask;
    logic                   lit;
    logic [3:0]             code_d;
    logic [NUM_DIGITS-1:0]  an_n_d;

    led7_blink_gen #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk                (clk),
        .rst_n              (rst_n),
        .wrap_i             (wrap),
        .blink_phase_next_o (blink_phase_d)
    );

    // Scan sequencer: gap, dwell, advance digit; disabling parks at the start of digit 0.
    always_comb begin
        st_d  = st_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (!en_i) begin
            st_d  = ST_BLANK;
            idx_d = '0;
            cnt_d = '0;
        end else begin
            unique case (st_q)
                ST_BLANK: begin
                    if (cnt_q == CntW'(GAP_CYC - 1)) begin
                        st_d  = ST_SHOW;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CntW'(DWELL_CYC - 1)) begin
                        st_d  = ST_BLANK;
                        cnt_d = '0;
                        if (idx_q == 3'(NUM_DIGITS - 1)) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

    // Double-buffered load: the displayed snapshot only changes at a frame wrap.
    always_comb begin
        snap_d  = snap_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        if (wrap) begin
            // A load landing on the wrap edge is newer than anything pending.
            if (load_i) begin
                snap_d = digits_i;
                pend_d = digits_i;
            end else if (pflag_q) begin
                snap_d = pend_q;
            end
            pflag_d = 1'b0;
        end else if (load_i) begin
            pend_d  = digits_i;
            pflag_d = 1'b1;
        end
    end

    // Output decode from next-state values so outputs move on the transition edge.
    always_comb begin
        cur_code = CODE_BLANK;
        cur_mask = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == 3'(k)) begin
                cur_code = snap_d[4*k +: 4];
                cur_mask = blink_mask_i[k];
            end
        end
        code_d = (blink_phase_d && cur_mask) ? CODE_BLANK : cur_code;
        // A blank code keeps its anode dark, covering both blinking and unloaded digits.
        lit    = (st_d == ST_SHOW) && (code_d != CODE_BLANK);
        an_n_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (lit && (idx_d == 3'(k))) begin
                an_n_d[k] = 1'b0;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= ST_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            snap_q       <= '1;
            pend_q       <= '1;
            pflag_q      <= 1'b0;
            code_o       <= CODE_BLANK;
            an_n_o       <= '1;
            digit_idx_o  <= '0;
            frame_done_o <= 1'b0;
        end else begin
            st_q         <= st_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            pend_q       <= pend_d;
            pflag_q      <= pflag_d;
            code_o       <= code_d;
            an_n_o       <= an_n_d;
            digit_idx_o  <= idx_d;
            frame_done_o <= wrap;
        end
    end

endmodule
